// File: rtl/ipm_sync_fifo_ctrl_if.sv
// Signal bundle between the FIFO controller, its producer/consumer and the simple-dual-port RAM.
// The controller uses the slave modport; the surrounding logic uses master.
interface ipm_sync_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_full;
  logic                  rd_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   wr_water_level;
  logic                  wr_ovf;
  logic                  rd_unf;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output wr_en, wr_data, rd_en, ram_rd_data,
    input  rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
           wr_water_level, wr_ovf, rd_unf, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ram_rd_data,
    output rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
           wr_water_level, wr_ovf, rd_unf, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );
endinterface

// File: rtl/ipm_sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, status flags and registered read data
// for a FIFO built on a distributed RAM with a combinational read path.
module ipm_sync_fifo_ctrl #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 4,
  parameter int ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input logic                 clk,
  input logic                 rst,
  ipm_sync_fifo_ctrl_if.slave fifo_if
);

  localparam int            PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LVL  = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_LVL  = PW'(ALMOST_EMPTY_NUM);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PTR_ONE;
  endfunction

  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_wr_ovf;
  logic                  r_rd_unf;

  logic [PW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;

  // Status decode and accept decisions from the pre-edge pointers.
  always_comb begin
    w_count     = r_wptr - r_rptr;
    w_empty     = (r_wptr == r_rptr);
    w_full      = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                  (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    w_wr_accept = fifo_if.wr_en & ~w_full & ~rst;
    w_rd_accept = fifo_if.rd_en & ~w_empty & ~rst;
  end

  // Pointer registers; reset flushes the FIFO without touching RAM contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wptr <= ptr_inc(r_wptr);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_rd_accept) begin
        r_rptr <= ptr_inc(r_rptr);
      end else begin
        r_rptr <= r_rptr;
      end
    end
  end

  // Read data capture and rd_valid pulse; rd_data holds between accepted reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_rd_accept) begin
      r_rd_data  <= fifo_if.ram_rd_data;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_data  <= r_rd_data;
      r_rd_valid <= 1'b0;
    end
  end

  // Rejected-request pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ovf <= 1'b0;
      r_rd_unf <= 1'b0;
    end else begin
      r_wr_ovf <= fifo_if.wr_en & w_full;
      r_rd_unf <= fifo_if.rd_en & w_empty;
    end
  end

  assign fifo_if.ram_wr_en      = w_wr_accept;
  assign fifo_if.ram_wr_addr    = r_wptr[ADDR_WIDTH-1:0];
  assign fifo_if.ram_wr_data    = fifo_if.wr_data;
  assign fifo_if.ram_rd_addr    = r_rptr[ADDR_WIDTH-1:0];

  assign fifo_if.rd_data        = r_rd_data;
  assign fifo_if.rd_valid       = r_rd_valid;
  assign fifo_if.wr_ovf         = r_wr_ovf;
  assign fifo_if.rd_unf         = r_rd_unf;
  assign fifo_if.wr_full        = w_full;
  assign fifo_if.rd_empty       = w_empty;
  assign fifo_if.almost_full    = (w_count >= AF_LVL);
  assign fifo_if.almost_empty   = (w_count <= AE_LVL);
  assign fifo_if.wr_water_level = w_count;

endmodule

// File: tb/tb_ipm_sync_fifo_ctrl.sv
// Self-checking bench for ipm_sync_fifo_ctrl: directed steps followed by randomised traffic,
// compared against a queue-based reference model.
module tb_ipm_sync_fifo_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2**AW;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ipm_sync_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ipm_sync_fifo_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
  ) dut (
    .clk(clk), .rst(rst), .fifo_if(bus)
  );

  // Distributed RAM stand-in: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  assign bus.ram_rd_data = mem[bus.ram_rd_addr];

  // Reference model state
  logic [DW-1:0] q[$];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic [DW-1:0] exp_rd_data = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_unf = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rd_data",      32'(bus.rd_data),        32'(exp_rd_data));
    chk("rd_valid",     32'(bus.rd_valid),       32'(exp_valid));
    chk("wr_full",      32'(bus.wr_full),        32'(q.size() == DEPTH));
    chk("rd_empty",     32'(bus.rd_empty),       32'(q.size() == 0));
    chk("almost_full",  32'(bus.almost_full),    32'(q.size() >= AF));
    chk("almost_empty", 32'(bus.almost_empty),   32'(q.size() <= AE));
    chk("water_level",  32'(bus.wr_water_level), 32'(q.size()));
    chk("wr_ovf",       32'(bus.wr_ovf),         32'(exp_ovf));
    chk("rd_unf",       32'(bus.rd_unf),         32'(exp_unf));
  endtask

  task automatic step(input logic r, input logic we, input logic [DW-1:0] wd, input logic re);
    bit full;
    bit empty;
    bit wacc;
    @(negedge clk);
    rst = r;
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.rd_en = re;
    #1;
    wacc = we && !r && (q.size() < DEPTH);
    chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(wacc));
    if (wacc) begin
      chk("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(wr_idx % DEPTH));
      chk("ram_wr_data", 32'(bus.ram_wr_data), 32'(wd));
    end
    if (!r) chk("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(rd_idx % DEPTH));
    @(posedge clk);
    if (r) begin
      q.delete();
      wr_idx = 0;
      rd_idx = 0;
      exp_rd_data = '0;
      exp_valid = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      exp_ovf   = we && full;
      exp_unf   = re && empty;
      exp_valid = re && !empty;
      if (exp_valid) begin
        exp_rd_data = q.pop_front();
        rd_idx++;
      end
      if (we && !full) begin
        q.push_back(wd);
        wr_idx++;
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int wbias;
    int rbias;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;

    // Reset then idle
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle_empty", 32'(bus.rd_empty), 32'd1);
    chk("idle_rd_data", 32'(bus.rd_data), 32'd0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
    chk("fill_full", 32'(bus.wr_full), 32'd1);

    // Overflow while full, then simultaneous at full
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", 32'(bus.wr_ovf), 32'd1);
    chk("ovf_level", 32'(bus.wr_water_level), 32'd16);
    step(1'b0, 1'b1, 8'hBB, 1'b1);
    chk("simul_full_level", 32'(bus.wr_water_level), 32'd15);
    chk("simul_full_data", 32'(bus.rd_data), 32'h01);

    // Drain, then underflow
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("last_read", 32'(bus.rd_data), 32'h10);
    chk("drain_empty", 32'(bus.rd_empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("unf_pulse", 32'(bus.rd_unf), 32'd1);
    chk("unf_hold", 32'(bus.rd_data), 32'h10);

    // Simultaneous at empty
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("simul_empty_level", 32'(bus.wr_water_level), 32'd1);

    // Steady state at count 5 across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, DW'($urandom), 1'b1);
    chk("steady_level", 32'(bus.wr_water_level), 32'd5);

    // Reset mid-stream at count 9
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0);
    chk("pre_rst_level", 32'(bus.wr_water_level), 32'd9);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("rst_level", 32'(bus.wr_water_level), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);

    // Randomised traffic with drifting bias so the FIFO swings between full and empty
    wbias = 50;
    rbias = 50;
    for (int c = 0; c < 10000; c++) begin
      if ((c % 400) == 0) begin
        wbias = $urandom_range(20, 80);
        rbias = $urandom_range(20, 80);
      end
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < wbias),
           DW'($urandom),
           ($urandom_range(0, 99) < rbias));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
